sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Synchronous SRAM-style responder: the slave end of the CPU's `*_sram_en/wen/addr/wdata/rdata` interface.
- Used on the data side; the instruction side is the same block with all `sram_wen` tied to 0.
- Contains a word-addressed RAM with byte-lane writes, one-cycle read latency, and a small config-register window (LED, switch, timer, write counter).
- Unmapped accesses set a sticky error flag.

Parameters:
- `ADDR_W`, 14, RAM word-address width; RAM is 2^ADDR_W words of 32 bits (64 KiB at default).
- `CONF_BASE`, 32'h1FAF_0000, base of the config window; only bits [31:16] are decoded.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `sram_en`  in  1  access strobe for this cycle.
- `sram_wen`  in  4  byte write enables; bit i = byte lane i (bits [8i+7:8i]); 4'b0000 = read.
- `sram_addr`  in  32  byte address; bits [1:0] ignored (word access).
- `sram_wdata`  in  32  write data, lane-aligned.
- `sram_rdata`  out  32  read data, valid the cycle after the accepted access.
- `sw`  in  8  external switch inputs, sampled when read.
- `led`  out  16  LED register.
- `err`  out  1  sticky unmapped-access flag.

Behaviour:
- Decode, in priority order:
  - RAM hit: `sram_addr[31:ADDR_W+2]==0`; word index = `sram_addr[ADDR_W+1:2]`.
  - CONF hit: `sram_addr[31:16]==CONF_BASE[31:16]`; register offset = `sram_addr[15:0]`.
  - Anything else is unmapped.
- Accepted access: `sram_en==1` in a cycle with `reset==0`. With `sram_en==0`: no RAM/register change, `sram_rdata` holds, the timer still counts.
- Read latency is exactly 1 cycle:
  - On every accepted access, `sram_rdata` loads the pre-write contents of the addressed location (read-first), including on write cycles.
  - Back-to-back accesses are allowed every cycle; there is no stall or ready signal.
- RAM write: for each set bit i of `sram_wen`, byte lane i of the word takes `sram_wdata` lane i; other lanes unchanged. Partial enables (e.g. 4'b0011, 4'b0100) must work.
- Config registers (offsets other than those below read 0, are ignored on write, and do not set `err`):
  - 0x0000 LED, RW, 16 bits: lanes 0–1 writable; lanes 2–3 ignored; reads return zero-extended.
  - 0x0004 SWITCH, RO: reads return `{24'b0,sw}`; writes ignored.
  - 0x0008 TIMER, RW, 32 bits: +1 every cycle, wrapping FFFF_FFFF→0. A write in the same cycle wins per enabled lane; non-enabled lanes take the incremented value. A read returns the value before this cycle's increment.
  - 0x000C WCOUNT, RO, 32 bits: +1 per accepted RAM write with `sram_wen!=0`; wraps. Config and unmapped writes do not count.
- Unmapped access (read or write):
  - `sram_rdata` loads 0.
  - No state changes.
  - `err` set to 1 from the next cycle; cleared only by `reset`.
- Reset (synchronous):
  - Outputs: `sram_rdata`=0, `led`=0, `err`=0.
  - Internal state: TIMER=0, WCOUNT=0.
  - RAM contents are not reset.
  - An access presented in a reset cycle is dropped entirely: no write, no `err`, no counter update.
  - Reset asserted between an access and its response: `sram_rdata` shows 0 in the following cycle, and that response is lost.
- Simultaneous write and read of the same word cannot occur (single port). Read-after-write to the same word in consecutive cycles returns the new data.

Test Plan:
- Reset, then write 0x1122_3344 with wen=4'hF to 0x0000_0010; next cycle read 0x10 → `sram_rdata`=0x1122_3344 one cycle after the read strobe; WCOUNT=1.
- Byte lanes: word 0x20 holds 0xAABB_CCDD; write wen=4'b0100, wdata=0x0055_0000; read → 0xAA55_CCDD. Then wen=4'b0011, wdata=0x0000_1234 → 0xAA55_1234.
- Read-first: word 0x30 holds 0x1; write 0x2 to 0x30 → `sram_rdata`=0x1 next cycle. Read 0x30 on the following cycle → 0x2.
- Config:
  - Write 0x0000_BEEF to CONF_BASE+0 → `led`=16'hBEEF.
  - `sw`=8'h5A, read CONF_BASE+4 → 0x0000_005A.
  - Write TIMER=0xFFFF_FFFE, then read it two cycles later → 0 (wrap verified).
- Unmapped read of 0x8000_0000 → `sram_rdata`=0 and `err`=1 next cycle. `err` stays 1 across 10 idle cycles; `reset` pulse → `err`=0.
- Reset mid-stream: write 0xDEAD_BEEF to 0x40 in the same cycle `reset`=1 → WCOUNT=0 after reset. Subsequent read of 0x40 does not return 0xDEAD_BEEF unless that value was written before reset.

Source files
------------

// File: rtl/sram_responder_if.sv
// CPU-side SRAM bus: strobe, byte enables, byte address, write data and
// registered read data.
interface sram_responder_if;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   modport master (
      output sram_en,
      output sram_wen,
      output sram_addr,
      output sram_wdata,
      input  sram_rdata
   );

   modport slave (
      input  sram_en,
      input  sram_wen,
      input  sram_addr,
      input  sram_wdata,
      output sram_rdata
   );
endinterface

// File: rtl/sram_responder.sv
// Slave end of the CPU SRAM bus: byte-lane RAM with one-cycle read-first
// response plus a small config window (LED, switch, timer, RAM write count).
module sram_responder #(
   parameter int          ADDR_W    = 14,
   parameter logic [31:0] CONF_BASE = 32'h1FAF_0000
) (
   input  logic              clk,
   input  logic              reset,
   sram_responder_if.slave   bus,
   input  logic [7:0]        sw,
   output logic [15:0]       led,
   output logic              err
);

   localparam int RAM_DEPTH = 1 << ADDR_W;

   typedef enum logic [13:0] {
      OFF_LED    = 14'h0000,
      OFF_SWITCH = 14'h0001,
      OFF_TIMER  = 14'h0002,
      OFF_WCOUNT = 14'h0003
   } conf_off_e;

   typedef enum logic {
      SRC_RAM = 1'b0,
      SRC_REG = 1'b1
   } rsrc_e;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wen);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++)
         if (wen[i]) res[8*i +: 8] = new_val[8*i +: 8];
      return res;
   endfunction

   // Decode and access qualification
   logic              accept;
   logic              is_write;
   logic              ram_hit;
   logic              conf_hit;
   logic              unmapped;
   logic [ADDR_W-1:0] word_idx;
   logic [13:0]       conf_off;

   assign accept   = bus.sram_en && !reset;
   assign is_write = |bus.sram_wen;
   assign ram_hit  = (bus.sram_addr[31:ADDR_W+2] == '0);
   assign conf_hit = !ram_hit && (bus.sram_addr[31:16] == CONF_BASE[31:16]);
   assign unmapped = !ram_hit && !conf_hit;
   assign word_idx = bus.sram_addr[ADDR_W+1:2];
   assign conf_off = bus.sram_addr[15:2];

   logic ram_acc;
   logic ram_wr;
   logic conf_acc;
   logic conf_wr;

   assign ram_acc  = accept && ram_hit;
   assign ram_wr   = ram_acc && is_write;
   assign conf_acc = accept && conf_hit;
   assign conf_wr  = conf_acc && is_write;

   // RAM: read-first, registered output
   logic [31:0] mem [RAM_DEPTH];
   logic [31:0] ram_q;

   // NOTE: the RAM array has no reset so it maps onto block RAM; only the
   // control/output registers around it are reset.
   always_ff @(posedge clk) begin
      if (ram_acc) ram_q <= mem[word_idx];
      if (ram_wr) begin
         for (int i = 0; i < 4; i++)
            if (bus.sram_wen[i]) mem[word_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      end
   end

   // Config registers
   logic [31:0] timer;
   logic [31:0] timer_inc;
   logic [31:0] timer_nxt;
   logic [31:0] wcount;
   logic [31:0] conf_rdata;

   assign timer_inc = timer + 32'd1;

   // NOTE: combinational blocks assign every output a default first so no
   // path through the case statements can infer a latch.
   always_comb begin
      timer_nxt = timer_inc;
      if (conf_wr && conf_off == OFF_TIMER)
         timer_nxt = lane_merge(timer_inc, bus.sram_wdata, bus.sram_wen);
   end

   always_comb begin
      conf_rdata = '0;
      case (conf_off)
         OFF_LED:    conf_rdata = {16'h0000, led};
         OFF_SWITCH: conf_rdata = {24'h000000, sw};
         OFF_TIMER:  conf_rdata = timer;
         OFF_WCOUNT: conf_rdata = wcount;
         default:    conf_rdata = '0;
      endcase
   end

   // NOTE: all state registers use non-blocking assignments so every
   // register samples pre-edge values, which is what gives read-first data.
   always_ff @(posedge clk) begin
      if (reset) begin
         led    <= '0;
         timer  <= '0;
         wcount <= '0;
         err    <= 1'b0;
      end else begin
         timer <= timer_nxt;
         if (conf_wr && conf_off == OFF_LED)
            led <= lane_merge({16'h0000, led}, bus.sram_wdata, {2'b00, bus.sram_wen[1:0]})[15:0];
         if (ram_wr)
            wcount <= wcount + 32'd1;
         if (accept && unmapped)
            err <= 1'b1;
      end
   end

   // Response path: selects RAM output or latched register/zero value
   rsrc_e       src_q;
   logic [31:0] reg_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q <= SRC_REG;
         reg_q <= '0;
      end else if (accept) begin
         src_q <= ram_hit ? SRC_RAM : SRC_REG;
         reg_q <= conf_hit ? conf_rdata : '0;
      end
   end

   assign bus.sram_rdata = (src_q == SRC_RAM) ? ram_q : reg_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: RAM lanes, read-first, config window,
// unmapped error flag and reset behaviour.
module tb_sram_responder;

   localparam logic [31:0] CONF = 32'h1FAF_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  sw = 8'h00;
   logic [15:0] led;
   logic        err;
   int          n_cmp = 0;
   int          n_err = 0;

   sram_responder_if bus();

   sram_responder #(.ADDR_W(14), .CONF_BASE(CONF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .sw    (sw),
      .led   (led),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One accepted access; returns 1 ns after the edge that captured it.
   task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      bus.sram_en    = 1'b1;
      bus.sram_wen   = wen;
      bus.sram_addr  = addr;
      bus.sram_wdata = wdata;
      @(posedge clk);
      #1;
      bus.sram_en  = 1'b0;
      bus.sram_wen = 4'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.sram_en    = 1'b0;
      bus.sram_wen   = 4'h0;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;

      // Reset state
      @(negedge clk); reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", bus.sram_rdata, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      @(negedge clk); reset = 1'b0;
      access(4'h0, CONF + 32'hC, 32'h0);
      check("rst_wcount", bus.sram_rdata, 32'h0);

      // Full-word write, read back, write count
      access(4'hF, 32'h10, 32'h1122_3344);
      access(4'h0, 32'h10, 32'h0);
      check("rd_0x10", bus.sram_rdata, 32'h1122_3344);
      access(4'h0, CONF + 32'hC, 32'h0);
      check("wcount_1", bus.sram_rdata, 32'd1);

      // Byte lanes
      access(4'hF, 32'h20, 32'hAABB_CCDD);
      access(4'b0100, 32'h20, 32'h0055_0000);
      access(4'h0, 32'h20, 32'h0);
      check("lane2", bus.sram_rdata, 32'hAA55_CCDD);
      access(4'b0011, 32'h20, 32'h0000_1234);
      access(4'h0, 32'h20, 32'h0);
      check("lane10", bus.sram_rdata, 32'hAA55_1234);

      // Read-first, then read-after-write
      access(4'hF, 32'h30, 32'h1);
      access(4'hF, 32'h30, 32'h2);
      check("read_first", bus.sram_rdata, 32'h1);
      access(4'h0, 32'h30, 32'h0);
      check("raw", bus.sram_rdata, 32'h2);
      access(4'hF, 32'h40, 32'h0BAD_F00D);

      // LED register
      access(4'hF, CONF, 32'h0000_BEEF);
      check("led_beef", {16'h0, led}, 32'h0000_BEEF);
      access(4'b1100, CONF, 32'h1234_5678);
      check("led_hi_ign", {16'h0, led}, 32'h0000_BEEF);
      access(4'b0001, CONF + 32'h1, 32'h0000_00AA);
      access(4'h0, CONF, 32'h0);
      check("led_rd", bus.sram_rdata, 32'h0000_BEAA);

      // Switch register
      sw = 8'h5A;
      access(4'hF, CONF + 32'h4, 32'hFFFF_FFFF);
      access(4'h0, CONF + 32'h4, 32'h0);
      check("sw_rd", bus.sram_rdata, 32'h0000_005A);

      // Timer: wrap and partial-lane write against the increment
      access(4'hF, CONF + 32'h8, 32'hFFFF_FFFE);
      access(4'h0, CONF + 32'h8, 32'h0);
      check("timer_pre", bus.sram_rdata, 32'hFFFF_FFFE);
      idle(1);
      access(4'h0, CONF + 32'h8, 32'h0);
      check("timer_wrap", bus.sram_rdata, 32'h0);
      access(4'hF, CONF + 32'h8, 32'hFFFF_FF00);
      access(4'b0001, CONF + 32'h8, 32'h0000_0012);
      access(4'h0, CONF + 32'h8, 32'h0);
      check("timer_lane", bus.sram_rdata, 32'hFFFF_FF12);

      // Unused config offset reads zero without error
      access(4'h0, CONF + 32'h10, 32'h0);
      check("conf_hole", bus.sram_rdata, 32'h0);
      check("conf_hole_err", {31'h0, err}, 32'h0);

      // rdata holds while idle
      access(4'h0, 32'h10, 32'h0);
      idle(3);
      check("hold", bus.sram_rdata, 32'h1122_3344);

      // Unmapped accesses
      access(4'h0, 32'h8000_0000, 32'h0);
      check("unm_rdata", bus.sram_rdata, 32'h0);
      check("unm_err", {31'h0, err}, 32'h1);
      access(4'hF, 32'h8000_0010, 32'h1234_5678);
      idle(10);
      check("err_sticky", {31'h0, err}, 32'h1);
      access(4'h0, CONF + 32'hC, 32'h0);
      check("wcount_7", bus.sram_rdata, 32'd7);

      // Reset with a write presented in the same cycle
      @(negedge clk);
      reset          = 1'b1;
      bus.sram_en    = 1'b1;
      bus.sram_wen   = 4'hF;
      bus.sram_addr  = 32'h40;
      bus.sram_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      check("rst_err_clr", {31'h0, err}, 32'h0);
      check("rst_rdata2", bus.sram_rdata, 32'h0);
      @(negedge clk);
      reset        = 1'b0;
      bus.sram_en  = 1'b0;
      bus.sram_wen = 4'h0;
      access(4'h0, CONF + 32'hC, 32'h0);
      check("wcount_rst", bus.sram_rdata, 32'h0);
      access(4'h0, 32'h40, 32'h0);
      check("drop_wr", bus.sram_rdata, 32'h0BAD_F00D);
      check("led_rst", {16'h0, led}, 32'h0);

      // Reset between an access and its response
      access(4'h0, 32'h10, 32'h0);
      check("pre_rst_rd", bus.sram_rdata, 32'h1122_3344);
      @(negedge clk); reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_resp_lost", bus.sram_rdata, 32'h0);
      @(negedge clk); reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
